// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus a small MMIO block
// (LEDs, switches, cycle counter, compare timer) with 0-cycle reads.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          LED_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_w,
    input  logic [31:0]      Addr_in,
    input  logic [31:0]      Data_in,
    input  logic [2:0]       dm_ctrl,
    input  logic [15:0]      sw_in,
    output logic [31:0]      Data_out,
    output logic [LED_W-1:0] leds,
    output logic             timer_irq,
    output logic             bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {
        ACC_W  = 3'b000,
        ACC_HS = 3'b001,
        ACC_HU = 3'b010,
        ACC_BS = 3'b011,
        ACC_BU = 3'b100
    } acc_e;

    typedef enum logic [3:0] {
        REG_LED    = 4'd0,
        REG_SW     = 4'd1,
        REG_CYCLE  = 4'd2,
        REG_CMP    = 4'd3,
        REG_IRQCLR = 4'd4
    } reg_e;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          ram_hit;
    logic          mmio_win;
    logic          mmio_hit;
    logic [3:0]    off;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   rshift;
    logic [15:0]   rhalf;
    logic [7:0]    rbyte;
    logic [31:0]   ram_rd;
    logic [31:0]   mmio_rd;
    logic [31:0]   cyc_q;
    logic [31:0]   cmp_q;
    logic          cmp_we;
    logic          clr_we;

    assign idx      = Addr_in[AW+1:2];
    assign ram_hit  = (Addr_in >> (AW + 2)) == 32'd0;
    assign mmio_win = Addr_in[31:6] == MMIO_BASE[31:6];
    assign off      = Addr_in[5:2];
    assign mmio_hit = mmio_win && (off <= REG_IRQCLR);
    assign cmp_we   = mem_w && mmio_hit && (off == REG_CMP);
    assign clr_we   = mem_w && mmio_hit && (off == REG_IRQCLR);

    // Sub-word stores replicate the low bits across lanes; the mask picks one.
    always_comb begin
        wmask = 4'b1111;
        wdata = Data_in;
        unique case (acc_e'(dm_ctrl))
            ACC_HS, ACC_HU: begin
                wmask = Addr_in[1] ? 4'b1100 : 4'b0011;
                wdata = {2{Data_in[15:0]}};
            end
            ACC_BS, ACC_BU: begin
                wmask = 4'b0001 << Addr_in[1:0];
                wdata = {4{Data_in[7:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_w && ram_hit && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) ram[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rword  = ram[idx];
    assign rshift = rword >> {Addr_in[1:0], 3'b000};
    assign rbyte  = rshift[7:0];
    assign rhalf  = Addr_in[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ram_rd = rword;
        unique case (acc_e'(dm_ctrl))
            ACC_HS:  ram_rd = {{16{rhalf[15]}}, rhalf};
            ACC_HU:  ram_rd = {16'h0000, rhalf};
            ACC_BS:  ram_rd = {{24{rbyte[7]}}, rbyte};
            ACC_BU:  ram_rd = {24'h000000, rbyte};
            default: ;
        endcase
    end

    always_comb begin
        mmio_rd = 32'd0;
        unique case (reg_e'(off))
            REG_LED:   mmio_rd = 32'(leds);
            REG_SW:    mmio_rd = {16'h0000, sw_in};
            REG_CYCLE: mmio_rd = cyc_q;
            REG_CMP:   mmio_rd = cmp_q;
            default:   ;
        endcase
    end

    always_comb begin
        Data_out = 32'd0;
        if (ram_hit)       Data_out = ram_rd;
        else if (mmio_hit) Data_out = mmio_rd;
    end

    // A compare match outranks a same-cycle interrupt clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds      <= '0;
            cyc_q     <= 32'd0;
            cmp_q     <= 32'hFFFF_FFFF;
            timer_irq <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (mem_w && mmio_hit && off == REG_LED) leds <= Data_in[LED_W-1:0];
            if (cmp_we) cmp_q <= Data_in;
            if (cyc_q == cmp_q) timer_irq <= 1'b1;
            else if (clr_we)    timer_irq <= 1'b0;
            if (!ram_hit && !mmio_hit) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level memory
// model and an event-level timer model.
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] Addr_in = 32'd0;
    logic [31:0] Data_in = 32'd0;
    logic [2:0]  dm_ctrl = 3'd0;
    logic [15:0] sw_in = 16'd0;
    logic [31:0] Data_out;
    logic [15:0] leds;
    logic        timer_irq;
    logic        bus_err;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  bmem [4096];
    logic [15:0] m_led;
    logic [31:0] m_cyc;
    logic [31:0] m_cmp;
    logic        m_irq;
    logic        m_berr;

    dmem_responder dut (
        .clk(clk), .reset(reset), .mem_w(mem_w), .Addr_in(Addr_in),
        .Data_in(Data_in), .dm_ctrl(dm_ctrl), .sw_in(sw_in),
        .Data_out(Data_out), .leds(leds), .timer_irq(timer_irq),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic in_ram(input logic [31:0] a);
        return a < 32'd4096;
    endfunction

    function automatic logic in_mmio(input logic [31:0] a);
        return a >= MB && a < MB + 32'd64 && a[5:2] <= 4'd4;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a,
                                           input logic [2:0] c);
        int p;
        logic [15:0] h;
        logic [7:0] b;
        logic [31:0] w;
        if (in_ram(a)) begin
            p = int'(a[11:0]);
            w = {bmem[(p & ~3) + 3], bmem[(p & ~3) + 2],
                 bmem[(p & ~3) + 1], bmem[p & ~3]};
            h = {bmem[(p & ~1) + 1], bmem[p & ~1]};
            b = bmem[p];
            case (c)
                3'd1: return {{16{h[15]}}, h};
                3'd2: return {16'h0, h};
                3'd3: return {{24{b[7]}}, b};
                3'd4: return {24'h0, b};
                default: return w;
            endcase
        end
        if (in_mmio(a)) begin
            case (a[5:2])
                4'd0: return {16'h0, m_led};
                4'd1: return {16'h0, sw_in};
                4'd2: return m_cyc;
                4'd3: return m_cmp;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic m_edge(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
        logic hit;
        logic clr;
        int p;
        hit = (m_cyc == m_cmp);
        clr = 1'b0;
        if (!in_ram(a) && !in_mmio(a)) m_berr = 1'b1;
        else if (we && in_ram(a)) begin
            p = int'(a[11:0]);
            case (c)
                3'd1, 3'd2: begin
                    bmem[p & ~1] = d[7:0];
                    bmem[(p & ~1) + 1] = d[15:8];
                end
                3'd3, 3'd4: bmem[p] = d[7:0];
                default: for (int k = 0; k < 4; k++)
                    bmem[(p & ~3) + k] = d[8*k +: 8];
            endcase
        end else if (we) begin
            case (a[5:2])
                4'd0: m_led = d[15:0];
                4'd3: m_cmp = d;
                4'd4: clr = 1'b1;
                default: ;
            endcase
        end
        if (hit) m_irq = 1'b1;
        else if (clr) m_irq = 1'b0;
        m_cyc = m_cyc + 32'd1;
    endtask

    task automatic m_reset();
        m_led = 16'd0;
        m_cyc = 32'd0;
        m_cmp = 32'hFFFF_FFFF;
        m_irq = 1'b0;
        m_berr = 1'b0;
    endtask

    task automatic step(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c);
        mem_w = we;
        Addr_in = a;
        Data_in = d;
        dm_ctrl = c;
        #1;
        check("rdata", Data_out, m_read(a, c));
        @(posedge clk);
        m_edge(we, a, d, c);
        #1;
        mem_w = 1'b0;
        check("leds", leds, m_led);
        check("irq", timer_irq, m_irq);
        check("berr", bus_err, m_berr);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0] off;
        int r;
        #2 reset = 1'b1;
        m_reset();
        Addr_in = MB + 32'd12;
        #1;
        check("rst_cmp", Data_out, 32'hFFFF_FFFF);
        check("rst_leds", leds, 32'd0);
        check("rst_irq", timer_irq, 32'd0);
        check("rst_berr", bus_err, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        step(1'b1, MB + 32'h0C, 32'd5, 3'd0);
        for (int i = 0; i < 6; i++) step(1'b0, MB + 32'h08, 32'd0, 3'd0);
        check("irq_at5", timer_irq, 32'd1);
        step(1'b1, MB + 32'h10, 32'd0, 3'd0);
        check("irq_clr", timer_irq, 32'd0);
        step(1'b1, MB + 32'h0C, m_cyc + 32'd1, 3'd0);
        step(1'b0, MB + 32'h08, 32'd0, 3'd0);
        step(1'b1, MB + 32'h0C, m_cyc + 32'd1, 3'd0);
        step(1'b1, MB + 32'h10, 32'd0, 3'd0);
        check("irq_setwins", timer_irq, 32'd1);
        step(1'b1, MB + 32'h10, 32'd0, 3'd0);

        for (int i = 0; i < 64; i++) step(1'b1, 32'(4 * i), $urandom, 3'd0);

        step(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0);
        step(1'b0, 32'h13, 32'd0, 3'd0);
        check("word_ign", Data_out, 32'hDEAD_BEEF);
        step(1'b1, 32'h11, 32'h80, 3'd3);
        step(1'b0, 32'h10, 32'd0, 3'd0);
        check("byte_merge", Data_out, 32'hDEAD_80EF);
        step(1'b0, 32'h11, 32'd0, 3'd3);
        step(1'b0, 32'h11, 32'd0, 3'd4);
        step(1'b1, 32'h12, 32'h1234, 3'd1);
        step(1'b0, 32'h12, 32'd0, 3'd1);
        step(1'b1, 32'h12, 32'h8001, 3'd1);
        step(1'b0, 32'h12, 32'd0, 3'd1);
        check("half_s", Data_out, 32'hFFFF_8001);
        step(1'b0, 32'h12, 32'd0, 3'd2);

        sw_in = 16'h00F0;
        step(1'b1, MB, 32'h0000_A5A5, 3'd0);
        step(1'b1, MB + 32'h04, 32'h1234_5678, 3'd0);
        step(1'b0, MB + 32'h04, 32'd0, 3'd0);
        check("sw_rd", Data_out, 32'h0000_00F0);

        for (int i = 0; i < 400; i++) begin
            sw_in = 16'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6) begin
                step(1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                     3'($urandom_range(0, 7)));
            end else begin
                off = 4'($urandom_range(0, 4));
                a = MB + 32'(off) * 32'd4 + 32'($urandom_range(0, 3));
                d = (off == 4'd3) ? m_cyc + 32'($urandom_range(1, 6))
                                  : $urandom;
                step(1'($urandom), a, d, 3'($urandom_range(0, 7)));
            end
        end

        reset = 1'b1;
        m_reset();
        mem_w = 1'b1;
        Addr_in = MB;
        Data_in = 32'h0000_FFFF;
        dm_ctrl = 3'd0;
        #1;
        check("arst_leds", leds, 32'd0);
        Addr_in = MB + 32'h08;
        #1;
        check("arst_cyc", Data_out, 32'd0);
        Addr_in = MB;
        @(posedge clk);
        #1;
        check("rst_wr_lost", leds, 32'd0);
        mem_w = 1'b0;
        reset = 1'b0;

        step(1'b1, MB, 32'h0000_3C3C, 3'd0);
        step(1'b0, 32'h8000_0000, 32'd0, 3'd0);
        check("unmap_berr", bus_err, 32'd1);
        step(1'b1, MB + 32'h20, 32'hFFFF_FFFF, 3'd0);
        step(1'b0, MB + 32'h00, 32'd0, 3'd0);
        step(1'b1, 32'h0010_0000, 32'h1111_1111, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'(4 * i), 32'd0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
